// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and its detector-side models.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    localparam int unsigned DEF_PAT_W = 3;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 3'b101;

endpackage

// File: rtl/seq_gap_timer.sv
// Loadable down-counter with a zero flag; times the idle dwell between patterns.
module seq_gap_timer #(
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [GAP_W-1:0] i_value,
    output logic             o_zero_c
);

    logic [GAP_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - GAP_W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: repeats PATTERN (MSB first) a programmed number of
// times with a programmable idle gap, flagging the last bit of each pattern.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int unsigned           PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0]      PATTERN = DEF_PATTERN,
    parameter int unsigned           CNT_W   = 8,
    parameter int unsigned           GAP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [GAP_W-1:0] gap,
    output logic             out,
    output logic             frame_mark,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_SEND = 2'(SEND);
    localparam logic [1:0] ST_GAP  = 2'(GAP);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_bit_idx;
    logic [CNT_W-1:0] r_rem;
    logic [GAP_W-1:0] r_gap;
    logic             r_out;
    logic             r_frame;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_state_n;
    logic [IDX_W-1:0] w_idx_n;
    logic [CNT_W-1:0] w_rem_n;
    logic [GAP_W-1:0] w_gap_n;
    logic             w_out_n;
    logic             w_frame_n;
    logic             w_busy_n;
    logic             w_done_n;
    logic             w_tmr_load;
    logic             w_tmr_dec;
    logic             w_tmr_zero;

    // Timer is loaded with gap-1 so its zero flag marks the final idle cycle.
    seq_gap_timer #(
        .GAP_W (GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_tmr_load),
        .i_dec    (w_tmr_dec),
        .i_value  (r_gap - GAP_W'(1)),
        .o_zero_c (w_tmr_zero)
    );

    // Next state and next registered outputs; r_bit_idx names the bit now on out.
    always_comb begin
        w_state_n  = r_state;
        w_idx_n    = r_bit_idx;
        w_rem_n    = r_rem;
        w_gap_n    = r_gap;
        w_out_n    = 1'b0;
        w_frame_n  = 1'b0;
        w_busy_n   = 1'b0;
        w_done_n   = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_dec  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_busy_n = 1'b1;
                    if (count != '0) begin
                        w_state_n = ST_SEND;
                        w_idx_n   = LAST_IDX;
                        w_rem_n   = count;
                        w_gap_n   = gap;
                        w_out_n   = PATTERN[LAST_IDX];
                    end else begin
                        w_state_n = ST_DONE;
                        w_done_n  = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                w_busy_n = 1'b1;
                if (r_bit_idx != '0) begin
                    w_idx_n   = r_bit_idx - IDX_W'(1);
                    w_out_n   = PATTERN[w_idx_n];
                    w_frame_n = (w_idx_n == '0);
                end else begin
                    w_rem_n = r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        w_state_n = ST_DONE;
                        w_done_n  = 1'b1;
                    end else if (r_gap == '0) begin
                        w_idx_n = LAST_IDX;
                        w_out_n = PATTERN[LAST_IDX];
                    end else begin
                        w_state_n  = ST_GAP;
                        w_tmr_load = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                w_busy_n = 1'b1;
                if (w_tmr_zero) begin
                    w_state_n = ST_SEND;
                    w_idx_n   = LAST_IDX;
                    w_out_n   = PATTERN[LAST_IDX];
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_idx <= '0;
            r_rem     <= '0;
            r_gap     <= '0;
            r_out     <= 1'b0;
            r_frame   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_bit_idx <= w_idx_n;
            r_rem     <= w_rem_n;
            r_gap     <= w_gap_n;
            r_out     <= w_out_n;
            r_frame   <= w_frame_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
        end
    end

    assign out        = r_out;
    assign frame_mark = r_frame;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: per-cycle expected-output queue built from the
// transfer rules, plus a non-overlapping Mealy detector fed from out.
module tb_seq_pattern_gen;
    import seq_pkg::*;

    localparam int unsigned PAT_W = DEF_PAT_W;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned GAP_W = 4;
    localparam logic [PAT_W-1:0] PAT = DEF_PATTERN;

    typedef logic [3:0] vec_t;  // {out, frame_mark, busy, done}

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [GAP_W-1:0] gap;
    logic             out;
    logic             frame_mark;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    seq_pattern_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .count      (count),
        .gap        (gap),
        .out        (out),
        .frame_mark (frame_mark),
        .busy       (busy),
        .done       (done)
    );

    vec_t exp_q[$];
    vec_t bld[$];
    vec_t cmp_e;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   chk_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Expected output stream of one accepted transfer, first bit to done cycle.
    task automatic append_txn(input int c, input int g);
        for (int r = 0; r < c; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                bld.push_back({PAT[b], (b == 0), 1'b1, 1'b0});
            if (r < c - 1)
                for (int k = 0; k < g; k++) bld.push_back(4'b0010);
        end
        bld.push_back(4'b0011);
    endtask

    task automatic pin(input int c, input int g, input int sz, input logic [31:0] ob,
                       input logic [31:0] fb, input logic [31:0] bb, input logic [31:0] db);
        logic [31:0] o, f, b, d;
        o = '0; f = '0; b = '0; d = '0;
        bld.delete();
        append_txn(c, g);
        foreach (bld[i]) begin
            o = {o[30:0], bld[i][3]};
            f = {f[30:0], bld[i][2]};
            b = {b[30:0], bld[i][1]};
            d = {d[30:0], bld[i][0]};
        end
        check("pin_len",   32'(bld.size()), 32'(sz));
        check("pin_out",   o, ob);
        check("pin_frame", f, fb);
        check("pin_busy",  b, bb);
        check("pin_done",  d, db);
    endtask

    // Reference detector: non-overlapping match of PAT on the serial stream.
    logic [PAT_W-1:0] det_win = '0;
    int               det_n   = 0;
    logic             det_hit;

    always_comb det_hit = (det_n >= int'(PAT_W) - 1) && ({det_win[PAT_W-2:0], out} == PAT);

    always @(posedge clk) begin
        if (rst || det_hit) begin
            det_n <= 0;
        end else begin
            det_win <= {det_win[PAT_W-2:0], out};
            det_n   <= (det_n < int'(PAT_W)) ? det_n + 1 : det_n;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0000;
            check("cycle", 32'({out, frame_mark, busy, done}), 32'(cmp_e));
            check("detector", 32'(det_hit), 32'(frame_mark));
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Drive one cycle of inputs and update the model with what the DUT must do.
    task automatic drive(input logic r, input logic s, input int c, input int g);
        rst   = r;
        start = s;
        count = CNT_W'(c);
        gap   = GAP_W'(g);
        if (r) begin
            while (exp_q.size() > 1) void'(exp_q.pop_back());
        end else if (s && exp_q.size() == 0) begin
            bld.delete();
            append_txn(c, g);
            exp_q.push_back(4'b0000);
            foreach (bld[i]) exp_q.push_back(bld[i]);
        end
        tick();
        rst   = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            drive(1'b0, 1'b0, 0, 0);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: %0d expected cycles pending, required 0", exp_q.size());
        end
        repeat (2) drive(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        count = '0;
        gap   = '0;
        tick();
        chk_en = 1'b1;
        drive(1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 0, 0);

        pin(1, 0, 4,  32'b1010,       32'b0010,       32'b1111,       32'b0001);
        pin(3, 0, 10, 32'b1011011010, 32'b0010010010, 32'b1111111111, 32'b0000000001);
        pin(2, 2, 9,  32'b101001010,  32'b001000010,  32'b111111111,  32'b000000001);
        pin(0, 5, 1,  32'b0,          32'b0,          32'b1,          32'b1);

        drive(1'b0, 1'b1, 1, 0);  wait_idle();
        drive(1'b0, 1'b1, 3, 0);  wait_idle();
        drive(1'b0, 1'b1, 2, 2);  wait_idle();
        drive(1'b0, 1'b1, 0, 7);  wait_idle();

        // start mid-SEND and during DONE are ignored; the cycle after DONE accepts
        drive(1'b0, 1'b1, 2, 1);
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 5, 3);
        n = 0;
        while (exp_q.size() > 1 && n < 100) begin
            drive(1'b0, 1'b0, 0, 0);
            n++;
        end
        check("reach_done", 32'(exp_q.size()), 32'd1);
        drive(1'b0, 1'b1, 4, 4);
        drive(1'b0, 1'b1, 1, 0);
        wait_idle();

        // reset on the second bit of a count=5 transfer, then a normal start
        drive(1'b0, 1'b1, 5, 0);
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 0, 0);
        repeat (4) drive(1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 2, 1);
        wait_idle();

        drive(1'b0, 1'b1, 255, 0);
        wait_idle();
        drive(1'b0, 1'b1, 3, 15);
        wait_idle();

        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 119) == 0),
                  ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 6)),
                  ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3)));
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
